uart: RTL and testbench
=======================

Name: uart

Overview:
- Board-level 8N1 UART block: receives serial bytes on uart_rx, shows the low 6 bits of the last good byte on active-low LEDs, and optionally echoes the byte on uart_tx.
- Sits directly at FPGA top level between the USB-UART bridge pins and the on-board LEDs.
- Bit timing comes from a single clock-cycles-per-bit parameter.

Parameters:
- WAIT_CYCLES, 234, clock cycles per UART bit (27 MHz / 115200). Must be ≥ 4 and even-safe; half-bit = WAIT_CYCLES/2 (integer division).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- btn  input  1  reset; synchronous, active-high.
- uart_rx  input  1  serial input; idle high.
- uart_tx  output  1  serial output; idle high.
- led  output  6  LED drive, active-low: led = ~rx_byte[5:0].

Behaviour:
- Reset (btn=1 at a clk edge): RX and TX FSMs → IDLE, counters = 0, rx shift reg = 0, led = 6'b111111, uart_tx = 1. Reset mid-frame aborts either FSM with no LED update.
- With no reset asserted, the power-up register state is undefined. The design must not deadlock from any state: the default case of each FSM returns to IDLE on the next clock.
- uart_rx is sampled raw; no synchronizer, to keep bit-center timing exact for small WAIT_CYCLES.
- RX format: 8N1, LSB first.
- RX FSM states and transitions:
  - IDLE: counter = 0. uart_rx = 0 → START.
  - START: count WAIT_CYCLES/2 − 1 cycles to the start-bit center. If uart_rx = 0 → DATA (counter = 0, bit index = 0), else → IDLE (glitch rejected).
  - DATA: count WAIT_CYCLES cycles, then sample uart_rx into shift[bit_index]. Increment the index. After bit 7 → STOP.
  - STOP: count WAIT_CYCLES cycles, then sample.
    - Sample 1: on the same edge commit the byte (led ← ~byte[5:0]) and issue a 1-cycle internal rx_done pulse.
    - Sample 0 (framing error): discard the byte; led unchanged.
    - Either way → IDLE.
- No new start is accepted until the FSM is back in IDLE. A line held low after a framing error simply restarts START and is glitch-checked again.
- Commit latency: about WAIT_CYCLES/2 + 9·WAIT_CYCLES cycles after the falling edge of the start bit.
- TX (under UART_ECHO_EN):
  - IDLE → on rx_done, latch the byte → START.
  - START (uart_tx = 0), DATA ×8 (LSB first), STOP (uart_tx = 1): each bit lasts exactly WAIT_CYCLES cycles → IDLE.
  - rx_done arriving while TX is not IDLE is dropped (overrun; no queue).
  - uart_tx is registered.

Optional Feature:
- Macro: UART_ECHO_EN.
- Defined: TX FSM present; every committed RX byte is retransmitted on uart_tx, starting 1 cycle after rx_done.
- Undefined: no TX logic; uart_tx tied to 1. RX and LED behaviour identical in both builds.

Test Plan:
- WAIT_CYCLES=8, 2 ns clock.
  - Stimulus: reset 2 cycles, rx idle high, then start bit followed by data bits 1,0,1,1,0,0,1,0 (8 cycles each) and stop bit 1.
  - Required: led = 6'b110010 (byte 0x4D) after the stop-bit center; unchanged before that.
- Glitch: rx low for 2 cycles then high → FSM back to IDLE, led stays 6'b111111.
- Framing error: byte 0xFF sent with stop bit 0 → led unchanged; next valid byte 0x01 → led = 6'b111110.
- Reset mid-frame: btn=1 during data bit 4 → led = 6'b111111 and FSM in IDLE next cycle; a following full byte 0x2A → led = 6'b010101.
- Echo (UART_ECHO_EN): after receiving 0x4D, uart_tx shows start 0, bits 1,0,1,1,0,0,1,0, then stop 1, each 8 cycles; without the macro uart_tx stays 1 throughout.
- Back-to-back: two bytes 0x3C, 0x03 with no idle gap → led = 6'b000011 then 6'b111100; the second echo is dropped only if TX is still busy.

Source files
------------

// File: rtl/uart.sv
// uart: 8N1 receiver that shows the low six bits of each good byte on active-low LEDs.
// Defining UART_ECHO_EN adds a transmitter that echoes every committed byte on uart_tx.
module uart #(
  parameter int WAIT_CYCLES = 234
) (
  input  logic       clk,
  input  logic       btn,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [5:0] led
);

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_END = CW'(WAIT_CYCLES / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        rx_state;
  state_t        rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    shift;
  logic          rx_tick;
  logic          rx_half;
  logic          rx_commit;

  always_ff @(posedge clk) begin
    if (btn) rx_state <= ST_IDLE;
    else     rx_state <= rx_next;
  end

  // uart_rx is used raw so the bit-centre sample point stays exact.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:  if (!uart_rx) rx_next = ST_START;
      ST_START: if (rx_half) rx_next = uart_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = ST_STOP;
      ST_STOP:  if (rx_tick) rx_next = ST_IDLE;
      default:  rx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_tick   = (rx_cnt == BIT_END);
    rx_half   = (rx_cnt == HALF_END);
    rx_commit = (rx_state == ST_STOP) && rx_tick && uart_rx;
  end

  always_ff @(posedge clk) begin
    if (btn) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      shift  <= '0;
      led    <= 6'b111111;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
        end
        ST_START: begin
          if (rx_half) begin
            rx_cnt <= '0;
            rx_idx <= '0;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            rx_cnt         <= '0;
            shift[rx_idx]  <= uart_rx;
            rx_idx         <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (rx_tick) rx_cnt <= '0;
          else         rx_cnt <= rx_cnt + CW'(1);
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_commit) led <= ~shift[5:0];
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

`ifdef UART_ECHO_EN
  state_t        tx_state;
  state_t        tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_byte;
  logic          tx_q;
  logic          tx_tick;
  logic          rx_done;

  always_ff @(posedge clk) begin
    if (btn) rx_done <= 1'b0;
    else     rx_done <= rx_commit;
  end

  always_ff @(posedge clk) begin
    if (btn) tx_state <= ST_IDLE;
    else     tx_state <= tx_next;
  end

  // rx_done seen outside IDLE is an overrun and is simply not acted on.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      ST_IDLE:  if (rx_done) tx_next = ST_START;
      ST_START: if (tx_tick) tx_next = ST_DATA;
      ST_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = ST_STOP;
      ST_STOP:  if (tx_tick) tx_next = ST_IDLE;
      default:  tx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_tick = (tx_cnt == BIT_END);
  end

  always_ff @(posedge clk) begin
    if (btn) begin
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_byte <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx_cnt <= '0;
          tx_idx <= '0;
          tx_q   <= 1'b1;
          if (rx_done) begin
            tx_byte <= shift;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_q   <= tx_byte[0];
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 3'd1;
            tx_q   <= (tx_idx == 3'd7) ? 1'b1 : tx_byte[tx_idx + 3'd1];
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (tx_tick) tx_cnt <= '0;
          else         tx_cnt <= tx_cnt + CW'(1);
        end
        default: begin
          tx_cnt <= '0;
          tx_q   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;
`else
  logic unused_bits;
  assign unused_bits = ^shift[7:6];
  assign uart_tx     = 1'b1;
`endif

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed 8N1 frames at 8 clocks per bit, checking LEDs, RX state and the echo line.
module tb_uart;

  localparam int W = 8;
`ifdef UART_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       btn = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [5:0] led;

  int checks = 0;
  int errors = 0;

  uart #(.WAIT_CYCLES(W)) dut (
    .clk     (clk),
    .btn     (btn),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .led     (led)
  );

  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (W) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    btn = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    checks++;
    if (led !== 6'b111111) begin
      errors++; $display("FAIL reset_led: got %b expected %b", led, 6'b111111);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx);
    end
    checks++;
    if (dut.rx_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dut.rx_state);
    end
  endtask

  task automatic test_glitch();
    uart_rx = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.rx_state !== 2'd1) begin
      errors++; $display("FAIL glitch_start: got %0d expected 1", dut.rx_state);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut.rx_state !== 2'd0) begin
      errors++; $display("FAIL glitch_idle: got %0d expected 0", dut.rx_state);
    end
    checks++;
    if (led !== 6'b111111) begin
      errors++; $display("FAIL glitch_led: got %b expected %b", led, 6'b111111);
    end
    repeat (W) @(negedge clk);
  endtask

  // 0x4D; the stop-bit centre falls on the fifth clock of the stop bit.
  task automatic test_rx_byte();
    logic [7:0] d;
    d = 8'h4D;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    checks++;
    if (led !== 6'b111111) begin
      errors++; $display("FAIL rx_led_before_stop: got %b expected %b", led, 6'b111111);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL rx_tx_idle: got %b expected 1", uart_tx);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (led !== 6'b111111) begin
      errors++; $display("FAIL rx_led_pre_centre: got %b expected %b", led, 6'b111111);
    end
    @(negedge clk);
    checks++;
    if (led !== 6'b110010) begin
      errors++; $display("FAIL rx_led_commit: got %b expected %b", led, 6'b110010);
    end
    repeat (3) @(negedge clk);
  endtask

  // Entered at the end of a frame's stop bit; samples each echoed bit mid-way.
  task automatic test_echo(input logic [7:0] d);
    logic [9:0] frame;
    logic       exp;
    frame = {1'b1, d, 1'b0};
    repeat (2) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      exp = ECHO ? frame[j] : 1'b1;
      checks++;
      if (uart_tx !== exp) begin
        errors++; $display("FAIL echo_bit%0d: got %b expected %b", j, uart_tx, exp);
      end
      if (j < 9) repeat (W) @(negedge clk);
    end
  endtask

  task automatic test_framing();
    send_frame(8'hFF, 1'b0);
    uart_rx = 1'b1;
    repeat (W) @(negedge clk);
    checks++;
    if (led !== 6'b110010) begin
      errors++; $display("FAIL framing_led_kept: got %b expected %b", led, 6'b110010);
    end
    send_frame(8'h01, 1'b1);
    checks++;
    if (led !== 6'b111110) begin
      errors++; $display("FAIL framing_next_byte: got %b expected %b", led, 6'b111110);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h55;
    repeat (W) @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    uart_rx = d[4];
    repeat (3) @(negedge clk);
    checks++;
    if (dut.rx_state !== 2'd2) begin
      errors++; $display("FAIL mid_state_data: got %0d expected 2", dut.rx_state);
    end
    btn = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    checks++;
    if (led !== 6'b111111) begin
      errors++; $display("FAIL mid_reset_led: got %b expected %b", led, 6'b111111);
    end
    checks++;
    if (dut.rx_state !== 2'd0) begin
      errors++; $display("FAIL mid_reset_state: got %0d expected 0", dut.rx_state);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL mid_reset_tx: got %b expected 1", uart_tx);
    end
    repeat (2 * W) @(negedge clk);
    send_frame(8'h2A, 1'b1);
    checks++;
    if (led !== 6'b010101) begin
      errors++; $display("FAIL mid_next_byte: got %b expected %b", led, 6'b010101);
    end
    repeat (12 * W) @(negedge clk);
  endtask

  // The second byte commits while the first echo is still in its stop bit, so it is not echoed.
  task automatic test_back_to_back();
    int lows;
    send_frame(8'h3C, 1'b1);
    checks++;
    if (led !== 6'b000011) begin
      errors++; $display("FAIL b2b_first_led: got %b expected %b", led, 6'b000011);
    end
    fork
      send_frame(8'h03, 1'b1);
      test_echo(8'h3C);
    join
    checks++;
    if (led !== 6'b111100) begin
      errors++; $display("FAIL b2b_second_led: got %b expected %b", led, 6'b111100);
    end
    lows = 0;
    for (int i = 0; i < 12 * W; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++; $display("FAIL b2b_overrun_dropped: got %0d low samples expected 0", lows);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rx_byte();
    test_echo(8'h4D);
    repeat (10) @(negedge clk);
    test_framing();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
